// File: rtl/axi_lite_master_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// axi_lite_master_pkg : AXI4-Lite widths, response codes, soc-control address map
// Rev 1.0
// -----------------------------------------------------------------------------
package axi_lite_master_pkg;

  localparam int AXI_ADDR_WIDTH   = 32;
  localparam int AXI_DATA_WIDTH   = 32;
  localparam int AXI_STROBE_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int AXI_RESP_WIDTH   = 2;
  localparam int AXI_PROT_WIDTH   = 3;

  localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_DECERR = 2'b11;

  // Core control slave: address hhhh_SSrr, SS selects the sub-block, rr the register.
  localparam logic [7:0] SUB_SEL_CTRL        = 8'h01;
  localparam logic [7:0] SUB_SEL_REGFILE     = 8'h02;
  localparam logic [7:0] CTRL_REG_CONTROL    = 8'h00;
  localparam logic [7:0] CTRL_REG_STATUS     = 8'h01;
  localparam logic [7:0] CTRL_REG_FAULT_ADDR = 8'h02;
  localparam logic [7:0] CTRL_REG_FAULT_MASK = 8'h03;
  localparam int         CTRL_REG_COUNT      = 8;
  localparam int         REGFILE_DEPTH       = 32;

  function automatic logic [7:0] addr_sub_sel(input logic [AXI_ADDR_WIDTH-1:0] addr);
    return addr[15:8];
  endfunction

  function automatic logic [7:0] addr_reg_off(input logic [AXI_ADDR_WIDTH-1:0] addr);
    return addr[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_master.sv
`default_nettype none
// -----------------------------------------------------------------------------
// axi_lite_master : single-outstanding AXI4-Lite initiator; optional watchdog via AXI_MASTER_TIMEOUT_EN
// Rev 1.0
// -----------------------------------------------------------------------------
module axi_lite_master
  import axi_lite_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        CLK,
  input  logic                        RSTn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [AXI_STROBE_WIDTH-1:0] cmd_wstrb,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [AXI_RESP_WIDTH-1:0]   rsp_resp,
  output logic                        rsp_timeout,
  output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [AXI_PROT_WIDTH-1:0]   M_AXI_AWPROT,
  output logic                        M_AXI_AWVALID,
  input  logic                        M_AXI_AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [AXI_STROBE_WIDTH-1:0] M_AXI_WSTRB,
  output logic                        M_AXI_WVALID,
  input  logic                        M_AXI_WREADY,
  input  logic [AXI_RESP_WIDTH-1:0]   M_AXI_BRESP,
  input  logic                        M_AXI_BVALID,
  output logic                        M_AXI_BREADY,
  output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [AXI_PROT_WIDTH-1:0]   M_AXI_ARPROT,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [AXI_RESP_WIDTH-1:0]   M_AXI_RRESP,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    RSP     = 3'd5
  } state_e;

  state_e                      state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [AXI_STROBE_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                        aw_done_q, aw_done_d;
  logic                        w_done_q, w_done_d;
  logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [AXI_RESP_WIDTH-1:0]   resp_q, resp_d;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (M_AXI_ARREADY) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (M_AXI_RVALID) begin
          rdata_d = M_AXI_RDATA;
          resp_d  = M_AXI_RRESP;
          state_d = RSP;
        end
      end
      WR_REQ: begin
        // A READY seen after its own handshake is harmless: the VALID is already low.
        aw_done_d = aw_done_q | M_AXI_AWREADY;
        w_done_d  = w_done_q  | M_AXI_WREADY;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          resp_d  = M_AXI_BRESP;
          rdata_d = '0;
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready     = (state_q == IDLE);
  assign rsp_valid     = (state_q == RSP);
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;

  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = '0;
  assign M_AXI_ARVALID = (state_q == RD_ADDR);
  assign M_AXI_RREADY  = (state_q == RD_DATA);
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = '0;
  assign M_AXI_AWVALID = (state_q == WR_REQ) && !aw_done_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = (state_q == WR_REQ) && !w_done_q;
  assign M_AXI_BREADY  = (state_q == WR_RESP);

`ifdef AXI_MASTER_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;
  logic        tmo_flag_q;
  logic        cmd_accept;
  logic        busy;

  assign cmd_accept = (state_q == IDLE) && cmd_valid;
  assign busy       = (state_q != IDLE) && (state_q != RSP);

  // Watchdog only reports; the bus transaction always runs to completion.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else if (cmd_accept) begin
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else if (busy) begin
      tmo_cnt_q <= tmo_cnt_q + 32'd1;
      if (tmo_cnt_q + 32'd1 >= TIMEOUT_CYCLES) tmo_flag_q <= 1'b1;
    end
  end

  assign rsp_timeout = tmo_flag_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^(32'(TIMEOUT_CYCLES));
  assign rsp_timeout        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_axi_lite_master : AXI4-Lite master bench with a wait-programmable control-slave model
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_axi_lite_master;
  import axi_lite_master_pkg::*;

  logic        CLK, RSTn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;

  axi_lite_master #(.TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- slave model (core control slave) ----------------
  int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  logic        r_pend = 1'b0, b_pend = 1'b0, aw_got = 1'b0, w_got = 1'b0;
  logic [31:0] aw_a = '0, w_d = '0, r_d = '0;
  logic [3:0]  w_s = '0;
  logic [1:0]  r_r = '0, b_r = '0;
  logic [31:0] s_rf [32];
  logic [31:0] s_ctrl [8];
  logic        aw_hs, w_hs, w_fire;
  logic [31:0] wa, wd;
  logic [3:0]  ws;

  assign ARREADY = (ar_cnt >= ar_wait);
  assign AWREADY = (aw_cnt >= aw_wait);
  assign WREADY  = (w_cnt >= w_wait);
  assign RVALID  = r_pend && (r_cnt >= r_wait);
  assign BVALID  = b_pend && (b_cnt >= b_wait);
  assign RDATA   = r_d;
  assign RRESP   = r_r;
  assign BRESP   = b_r;
  assign aw_hs   = AWVALID && AWREADY;
  assign w_hs    = WVALID && WREADY;
  assign w_fire  = (aw_got || aw_hs) && (w_got || w_hs);
  assign wa      = aw_got ? aw_a : AWADDR;
  assign wd      = w_got ? w_d : WDATA;
  assign ws      = w_got ? w_s : WSTRB;

  function automatic logic s_ok(input logic [31:0] a);
    return (a[15:8] == 8'h01 && a[7:0] < 8) || (a[15:8] == 8'h02 && a[7:0] < 32);
  endfunction
  function automatic logic [1:0] s_err(input logic [31:0] a);
    return (a[15:8] == 8'h01 || a[15:8] == 8'h02) ? 2'b10 : 2'b11;
  endfunction

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
      r_pend <= 1'b0; b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      aw_a <= '0; w_d <= '0; w_s <= '0; r_d <= '0; r_r <= '0; b_r <= '0;
      for (int i = 0; i < 32; i++) s_rf[i] <= '0;
      for (int i = 0; i < 8; i++) s_ctrl[i] <= '0;
    end else begin
      if (ARVALID && ARREADY) begin
        ar_cnt <= 0; r_pend <= 1'b1; r_cnt <= 0;
        if (s_ok(ARADDR)) begin
          r_d <= (ARADDR[15:8] == 8'h02) ? s_rf[ARADDR[4:0]] : s_ctrl[ARADDR[2:0]];
          r_r <= 2'b00;
        end else begin
          r_d <= '0; r_r <= s_err(ARADDR);
        end
      end else if (ARVALID) ar_cnt <= ar_cnt + 1;
      if (r_pend) begin
        if (RVALID && RREADY) r_pend <= 1'b0; else r_cnt <= r_cnt + 1;
      end
      if (aw_hs) begin aw_got <= 1'b1; aw_a <= AWADDR; aw_cnt <= 0; end
      else if (AWVALID) aw_cnt <= aw_cnt + 1;
      if (w_hs) begin w_got <= 1'b1; w_d <= WDATA; w_s <= WSTRB; w_cnt <= 0; end
      else if (WVALID) w_cnt <= w_cnt + 1;
      if (w_fire) begin
        aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; b_cnt <= 0;
        if (s_ok(wa) && ws == 4'hF) begin
          if (wa[15:8] == 8'h02) s_rf[wa[4:0]] <= wd; else s_ctrl[wa[2:0]] <= wd;
          b_r <= 2'b00;
        end else b_r <= s_ok(wa) ? 2'b10 : s_err(wa);
      end
      if (b_pend) begin
        if (BVALID && BREADY) b_pend <= 1'b0; else b_cnt <= b_cnt + 1;
      end
    end
  end

  // ---------------- protocol monitor ----------------
  logic        p_ar = 1'b0, p_aw = 1'b0, p_w = 1'b0;
  logic [31:0] p_ar_a = '0, p_aw_a = '0, p_w_d = '0;
  logic [3:0]  p_w_s = '0;
  int          aw_hs_cnt = 0, w_hs_cnt = 0, proto_err = 0;
  logic        bad_ar, bad_aw, bad_w;
  assign bad_ar = p_ar && (!ARVALID || ARADDR != p_ar_a);
  assign bad_aw = p_aw && (!AWVALID || AWADDR != p_aw_a);
  assign bad_w  = p_w  && (!WVALID || WDATA != p_w_d || WSTRB != p_w_s);

  always @(posedge CLK) begin
    if (!RSTn) begin
      p_ar <= 1'b0; p_aw <= 1'b0; p_w <= 1'b0;
    end else begin
      proto_err <= proto_err + int'(bad_ar) + int'(bad_aw) + int'(bad_w);
      p_ar <= ARVALID && !ARREADY; p_ar_a <= ARADDR;
      p_aw <= AWVALID && !AWREADY; p_aw_a <= AWADDR;
      p_w  <= WVALID && !WREADY;   p_w_d  <= WDATA; p_w_s <= WSTRB;
      if (aw_hs) aw_hs_cnt <= aw_hs_cnt + 1;
      if (w_hs)  w_hs_cnt  <= w_hs_cnt + 1;
    end
  end

  // ---------------- reference model (address -> value) ----------------
  logic [31:0] model [logic [15:0]];

  function automatic logic [1:0] exp_resp(input logic w, input logic [31:0] a, input logic [3:0] s);
    logic [7:0] sel, off;
    sel = addr_sub_sel(a);
    off = addr_reg_off(a);
    if (sel != SUB_SEL_CTRL && sel != SUB_SEL_REGFILE) return AXI_RESP_DECERR;
    if (sel == SUB_SEL_CTRL && off >= CTRL_REG_COUNT) return AXI_RESP_SLVERR;
    if (sel == SUB_SEL_REGFILE && off >= REGFILE_DEPTH) return AXI_RESP_SLVERR;
    if (w && s != 4'hF) return AXI_RESP_SLVERR;
    return AXI_RESP_OKAY;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    if (exp_resp(1'b0, a, 4'hF) != AXI_RESP_OKAY) return '0;
    return model.exists(a[15:0]) ? model[a[15:0]] : 32'h0;
  endfunction

  // ---------------- checking ----------------
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int hold,
                        output logic [31:0] rd, output logic [1:0] rr,
                        output logic tmo, output int lat);
    int guard;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 100) begin @(posedge CLK); #1; guard++; end
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(posedge CLK); #1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(posedge CLK); #1; lat++; end
    chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    rd = rsp_rdata; rr = rsp_resp; tmo = rsp_timeout;
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1;
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, rd);
      chk("hold_resp", 32'(rsp_resp), 32'(rr));
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("hold_axi_idle", 32'({ARVALID, AWVALID, WVALID, RREADY, BREADY}), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
    chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [1:0]  er;
    logic [31:0] ed;
  } vec_t;

  vec_t        vt [9];
  logic [31:0] rd, a, d, exp_d;
  logic [1:0]  rr, exp_r;
  logic [3:0]  s;
  logic        tmo, w;
  int          lat, exp_lat, aw0, w0;
  int          aww [3];
  int          wwt [3];

  initial begin
    RSTn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b0;
    vt[0] = '{1'b1, 32'h0000_0203, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
    vt[1] = '{1'b0, 32'h0000_0203, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
    vt[2] = '{1'b0, 32'h0000_0240, 32'h0,         4'h0, 2'b10, 32'h0};
    vt[3] = '{1'b1, 32'h0000_0203, 32'h1234_5678, 4'h3, 2'b10, 32'h0};
    vt[4] = '{1'b0, 32'h0000_0203, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
    vt[5] = '{1'b1, 32'h5A5A_0105, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0};
    vt[6] = '{1'b0, 32'h0000_0105, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D};
    vt[7] = '{1'b0, 32'h0000_0300, 32'h0,         4'h0, 2'b11, 32'h0};
    vt[8] = '{1'b0, 32'hABCD_021F, 32'h0,         4'h0, 2'b00, 32'h0};
    aww[0] = 0; wwt[0] = 3;
    aww[1] = 3; wwt[1] = 0;
    aww[2] = 2; wwt[2] = 2;

    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_valids", 32'({ARVALID, AWVALID, WVALID, RREADY, BREADY, rsp_valid, rsp_timeout}), 32'd0);
    chk("rst_araddr", ARADDR, 32'd0);
    chk("rst_awaddr", AWADDR, 32'd0);
    chk("rst_wdata", WDATA, 32'd0);
    chk("rst_wstrb_prot", 32'({WSTRB, AWPROT, ARPROT}), 32'd0);
    chk("rst_rsp", 32'({rsp_rdata, rsp_resp}), 32'd0);
    @(posedge CLK); #1; RSTn = 1'b1;
    @(posedge CLK); #1;

    // Directed vectors against a zero-wait slave.
    foreach (vt[i]) begin
      do_txn(vt[i].w, vt[i].a, vt[i].d, vt[i].s, 0, rd, rr, tmo, lat);
      chk($sformatf("vec%0d_resp", i), 32'(rr), 32'(vt[i].er));
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].ed);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      chk($sformatf("vec%0d_timeout", i), 32'(tmo), 32'd0);
      if (vt[i].w && vt[i].er == 2'b00) model[vt[i].a[15:0]] = vt[i].d;
    end

    // Response held off for 10 cycles.
    do_txn(1'b0, 32'h0000_0203, 32'h0, 4'h0, 10, rd, rr, tmo, lat);
    chk("hold_read_data", rd, 32'hDEAD_BEEF);

    // AW-first, W-first and simultaneous write acceptance.
    for (int v = 0; v < 3; v++) begin
      aw_wait = aww[v]; w_wait = wwt[v];
      aw0 = aw_hs_cnt; w0 = w_hs_cnt;
      d = $urandom;
      do_txn(1'b1, 32'h0000_0210 + 32'(v), d, 4'hF, 0, rd, rr, tmo, lat);
      chk($sformatf("order%0d_resp", v), 32'(rr), 32'd0);
      chk($sformatf("order%0d_aw_hs", v), 32'(aw_hs_cnt - aw0), 32'd1);
      chk($sformatf("order%0d_w_hs", v), 32'(w_hs_cnt - w0), 32'd1);
      chk($sformatf("order%0d_latency", v), 32'(lat), 32'(3 + ((aww[v] > wwt[v]) ? aww[v] : wwt[v])));
      model[16'h0210 + 16'(v)] = d;
      do_txn(1'b0, 32'h0000_0210 + 32'(v), 32'h0, 4'h0, 0, rd, rr, tmo, lat);
      chk($sformatf("order%0d_readback", v), rd, d);
    end
    aw_wait = 0; w_wait = 0;

    // Reset while ARVALID is stalled on ARREADY.
    ar_wait = 1000;
    cmd_write = 1'b0; cmd_addr = 32'h0000_0203; cmd_valid = 1'b1;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("stall_arvalid", 32'(ARVALID), 32'd1);
    #2 RSTn = 1'b0;
    #1;
    chk("midrst_valids", 32'({ARVALID, AWVALID, WVALID, rsp_valid}), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge CLK); #1;
    ar_wait = 0;
    model.delete();
    RSTn = 1'b1;
    @(posedge CLK); #1;
    do_txn(1'b0, 32'h0000_0203, 32'h0, 4'h0, 0, rd, rr, tmo, lat);
    chk("post_rst_resp", 32'(rr), 32'd0);
    chk("post_rst_rdata", rd, 32'h0);
    chk("post_rst_latency", 32'(lat), 32'd3);

    // Randomized traffic with random slave wait states.
    for (int n = 0; n < 60; n++) begin
      ar_wait = $urandom_range(0, 3); r_wait = $urandom_range(0, 3);
      aw_wait = $urandom_range(0, 3); w_wait = $urandom_range(0, 3); b_wait = $urandom_range(0, 3);
      w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       a = {16'($urandom), 8'h01, 8'($urandom_range(0, 10))};
        3:       a = {16'($urandom), 8'h03, 8'($urandom_range(0, 10))};
        default: a = {16'($urandom), 8'h02, 8'($urandom_range(0, 35))};
      endcase
      s = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
      d = $urandom;
      exp_r = exp_resp(w, a, s);
      exp_d = w ? 32'h0 : exp_rdata(a);
      exp_lat = w ? 3 + ((aw_wait > w_wait) ? aw_wait : w_wait) + b_wait : 3 + ar_wait + r_wait;
      do_txn(w, a, d, s, $urandom_range(0, 2), rd, rr, tmo, lat);
      chk($sformatf("rnd%0d_resp", n), 32'(rr), 32'(exp_r));
      chk($sformatf("rnd%0d_rdata", n), rd, exp_d);
      chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'(exp_lat));
      chk($sformatf("rnd%0d_timeout", n), 32'(tmo), 32'd0);
      if (w && exp_r == AXI_RESP_OKAY) model[a[15:0]] = d;
    end
    ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;

`ifdef AXI_MASTER_TIMEOUT_EN
    ar_wait = 20;
    exp_d = exp_rdata(32'h0000_0203);
    do_txn(1'b0, 32'h0000_0203, 32'h0, 4'h0, 0, rd, rr, tmo, lat);
    chk("tmo_flag", 32'(tmo), 32'd1);
    chk("tmo_rdata", rd, exp_d);
    chk("tmo_latency", 32'(lat), 32'd23);
    ar_wait = 0;
    do_txn(1'b0, 32'h0000_0203, 32'h0, 4'h0, 0, rd, rr, tmo, lat);
    chk("tmo_clear", 32'(tmo), 32'd0);
`endif

    @(posedge CLK); #1;
    chk("protocol_stability", 32'(proto_err), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
